// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: word width, FSM encoding and the
// even-parity helper used when MEM_RESPONDER_PARITY_EN is defined.
package mem_responder_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Bit that makes the total count of ones (data plus parity) even.
  function automatic logic even_parity(input logic [WORD_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word array: one read or one write per enabled cycle.
// Contents are deliberately not reset; read data is registered and holds when idle.
module mem_array #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 32,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage write or registered read on each enabled cycle.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder between a control unit's MAR/MDR and a word array.
// Optional per-word even parity is enabled by defining MEM_RESPONDER_PARITY_EN.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              read,
  input  logic              write,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic              overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
`ifdef MEM_RESPONDER_PARITY_EN
  localparam int MW = WORD_W + 1;
`else
  localparam int MW = WORD_W;
`endif

  state_t            state_r;
  logic              read_r, write_r;
  logic [3:0]        count_r;
  logic [AW-1:0]     addr_r;
  logic [WORD_W-1:0] wdata_r;
  logic              write_op_r, reject_r;
  logic [WORD_W-1:0] rdata_r;
  logic              done_r, busy_r, err_r, overrun_r;

  logic              request_s, capture_s, addr_bad_s, conflict_s, parity_err_s;
  logic              mem_en_s, mem_we_s;
  logic [AW-1:0]     mem_addr_s;
  logic [MW-1:0]     mem_wdata_s, mem_rdata_s;

  assign request_s  = (read | write) & ~(read_r | write_r);
  assign capture_s  = request_s & (state_r == ST_IDLE);
  assign addr_bad_s = (addr >= 32'(DEPTH));
  assign conflict_s = read & write;

`ifdef MEM_RESPONDER_PARITY_EN
  assign mem_wdata_s  = {even_parity(wdata_r), wdata_r};
  assign parity_err_s = mem_rdata_s[WORD_W] != even_parity(mem_rdata_s[WORD_W-1:0]);
`else
  assign mem_wdata_s  = wdata_r;
  assign parity_err_s = 1'b0;
`endif

  // Reads are issued at capture so data is ready by the ACCESS exit edge;
  // writes commit only on that exit edge, so a reset in ACCESS blocks them.
  always_comb begin
    mem_en_s   = 1'b0;
    mem_we_s   = 1'b0;
    mem_addr_s = addr_r;
    if (capture_s) begin
      mem_addr_s = addr[AW-1:0];
      mem_en_s   = ~write & ~addr_bad_s;
    end else if (state_r == ST_ACCESS) begin
      mem_en_s = write_op_r & ~reject_r;
      mem_we_s = write_op_r & ~reject_r;
    end else begin
      mem_en_s = 1'b0;
    end
  end

  mem_array #(
    .DEPTH(DEPTH),
    .WIDTH(MW),
    .AW   (AW)
  ) u_array (
    .clk  (clk),
    .en   (mem_en_s),
    .we   (mem_we_s),
    .addr (mem_addr_s),
    .wdata(mem_wdata_s),
    .rdata(mem_rdata_s)
  );

  // Transaction FSM with strobe history and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      read_r     <= 1'b0;
      write_r    <= 1'b0;
      count_r    <= 4'd0;
      addr_r     <= '0;
      wdata_r    <= '0;
      write_op_r <= 1'b0;
      reject_r   <= 1'b0;
      rdata_r    <= '0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      read_r  <= read;
      write_r <= write;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      if (request_s && (state_r != ST_IDLE)) begin
        overrun_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (capture_s) begin
            addr_r     <= addr[AW-1:0];
            wdata_r    <= wdata;
            write_op_r <= write;
            reject_r   <= conflict_s | addr_bad_s;
            busy_r     <= 1'b1;
            count_r    <= WAIT_INIT;
            state_r    <= (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
          end
        end
        ST_WAIT: begin
          count_r <= count_r - 4'd1;
          if (count_r <= 4'd1) begin
            state_r <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!write_op_r && !reject_r) begin
            rdata_r  <= mem_rdata_s[WORD_W-1:0];
            reject_r <= parity_err_s;
          end
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          err_r   <= reject_r;
          state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign rdata   = rdata_r;
  assign done    = done_r;
  assign busy    = busy_r;
  assign err     = err_r;
  assign overrun = overrun_r;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with one wait state, one with none.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rd_1 = 1'b0, wr_1 = 1'b0, rd_0 = 1'b0, wr_0 = 1'b0;
  logic [31:0] addr_1 = 32'd0, wdata_1 = 32'd0, addr_0 = 32'd0, wdata_0 = 32'd0;
  logic [31:0] rdata_1, rdata_0;
  logic        done_1, busy_1, err_1, overrun_1;
  logic        done_0, busy_0, err_0, overrun_0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(512), .WAIT_STATES(1)) dut (
    .clk(clk), .reset_n(reset_n), .read(rd_1), .write(wr_1), .addr(addr_1), .wdata(wdata_1),
    .rdata(rdata_1), .done(done_1), .busy(busy_1), .err(err_1), .overrun(overrun_1)
  );

  mem_responder #(.DEPTH(512), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .reset_n(reset_n), .read(rd_0), .write(wr_0), .addr(addr_0), .wdata(wdata_0),
    .rdata(rdata_0), .done(done_0), .busy(busy_0), .err(err_0), .overrun(overrun_0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit ws0, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (ws0) begin
      rd_0 = rd; wr_0 = wr; addr_0 = a; wdata_0 = d;
    end else begin
      rd_1 = rd; wr_1 = wr; addr_1 = a; wdata_1 = d;
    end
  endtask

  // One transaction: strobes held for 'hold' cycles, then a bounded watch for done.
  // lat counts cycles from the capture edge to done high (-1 if done never came).
  task automatic txn(input bit ws0, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input int hold, output int lat,
                     output logic errv, output int ndone, output logic busy_seen);
    lat = -1; errv = 1'b0; ndone = 0; busy_seen = 1'b0;
    @(negedge clk);
    drive(ws0, rd, wr, a, d);
    for (int n = 1; n <= hold + 10; n++) begin
      @(negedge clk);
      if (n == hold) drive(ws0, 1'b0, 1'b0, a, d);
      if (n == 1) busy_seen = ws0 ? busy_0 : busy_1;
      if (ws0 ? done_0 : done_1) begin
        ndone++;
        if (lat < 0) begin
          lat  = n - 1;
          errv = ws0 ? err_0 : err_1;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ndone;
    logic errv, bsy;

    repeat (3) @(negedge clk);
    #1;
    check("reset_rdata", rdata_1, 32'h0);
    check("reset_done", {31'd0, done_1}, 32'd0);
    check("reset_busy", {31'd0, busy_1}, 32'd0);
    check("reset_err", {31'd0, err_1}, 32'd0);
    check("reset_overrun", {31'd0, overrun_1}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic write then read, one wait state
    txn(1'b0, 1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 1, lat, errv, ndone, bsy);
    check("wr5_latency", 32'(lat), 32'd3);
    check("wr5_err", {31'd0, errv}, 32'd0);
    check("wr5_ndone", 32'(ndone), 32'd1);
    check("wr5_busy", {31'd0, bsy}, 32'd1);
    txn(1'b0, 1'b1, 1'b0, 32'd5, 32'd0, 1, lat, errv, ndone, bsy);
    check("rd5_latency", 32'(lat), 32'd3);
    check("rd5_err", {31'd0, errv}, 32'd0);
    check("rd5_rdata", rdata_1, 32'hDEADBEEF);

    // No wait states, read held for four cycles
    txn(1'b1, 1'b0, 1'b1, 32'd7, 32'hCAFEF00D, 1, lat, errv, ndone, bsy);
    check("ws0_wr7_latency", 32'(lat), 32'd2);
    txn(1'b1, 1'b1, 1'b0, 32'd7, 32'd0, 4, lat, errv, ndone, bsy);
    check("ws0_hold_ndone", 32'(ndone), 32'd1);
    check("ws0_hold_latency", 32'(lat), 32'd2);
    check("ws0_hold_overrun", {31'd0, overrun_0}, 32'd0);
    check("ws0_rd7_rdata", rdata_0, 32'hCAFEF00D);

    // Simultaneous read/write rise is rejected
    txn(1'b0, 1'b0, 1'b1, 32'd3, 32'h11111111, 1, lat, errv, ndone, bsy);
    txn(1'b0, 1'b1, 1'b1, 32'd3, 32'h22222222, 1, lat, errv, ndone, bsy);
    check("both_err", {31'd0, errv}, 32'd1);
    check("both_latency", 32'(lat), 32'd3);
    check("both_ndone", 32'(ndone), 32'd1);
    check("both_rdata_held", rdata_1, 32'hDEADBEEF);
    txn(1'b0, 1'b1, 1'b0, 32'd3, 32'd0, 1, lat, errv, ndone, bsy);
    check("rd3_err", {31'd0, errv}, 32'd0);
    check("rd3_rdata", rdata_1, 32'h11111111);

    // Address range boundaries
    txn(1'b0, 1'b0, 1'b1, 32'd0, 32'hA5A5A5A5, 1, lat, errv, ndone, bsy);
    txn(1'b0, 1'b0, 1'b1, 32'd512, 32'h0, 1, lat, errv, ndone, bsy);
    check("wr512_err", {31'd0, errv}, 32'd1);
    txn(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1, lat, errv, ndone, bsy);
    check("rd0_err", {31'd0, errv}, 32'd0);
    check("rd0_rdata", rdata_1, 32'hA5A5A5A5);
    txn(1'b0, 1'b1, 1'b0, 32'd600, 32'd0, 1, lat, errv, ndone, bsy);
    check("rd600_err", {31'd0, errv}, 32'd1);
    check("rd600_rdata_held", rdata_1, 32'hA5A5A5A5);
    txn(1'b0, 1'b0, 1'b1, 32'd511, 32'h0F0F0F0F, 1, lat, errv, ndone, bsy);
    txn(1'b0, 1'b1, 1'b0, 32'd511, 32'd0, 1, lat, errv, ndone, bsy);
    check("rd511_err", {31'd0, errv}, 32'd0);
    check("rd511_rdata", rdata_1, 32'h0F0F0F0F);

    // Second read edge while busy: ignored, sets sticky overrun
    ndone = 0;
    @(negedge clk); drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    if (done_1) ndone++;
    @(negedge clk); drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
    if (done_1) ndone++;
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    if (done_1) ndone++;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done_1) ndone++;
    end
    check("overrun_ndone", 32'(ndone), 32'd1);
    check("overrun_set", {31'd0, overrun_1}, 32'd1);
    txn(1'b0, 1'b1, 1'b0, 32'd5, 32'd0, 1, lat, errv, ndone, bsy);
    check("overrun_sticky", {31'd0, overrun_1}, 32'd1);

    // Reset during ACCESS of a write must abort it
    txn(1'b0, 1'b0, 1'b1, 32'd9, 32'h55555555, 1, lat, errv, ndone, bsy);
    ndone = 0;
    @(negedge clk); drive(1'b0, 1'b0, 1'b1, 32'd9, 32'h12345678);
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 32'd9, 32'h12345678);
    @(negedge clk); reset_n = 1'b0;
    #1;
    check("rst_rdata", rdata_1, 32'h0);
    check("rst_done", {31'd0, done_1}, 32'd0);
    check("rst_busy", {31'd0, busy_1}, 32'd0);
    check("rst_err", {31'd0, err_1}, 32'd0);
    check("rst_overrun", {31'd0, overrun_1}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done_1) ndone++;
    end
    check("rst_no_done", 32'(ndone), 32'd0);
    txn(1'b0, 1'b1, 1'b0, 32'd9, 32'd0, 1, lat, errv, ndone, bsy);
    check("rd9_after_rst", rdata_1, 32'h55555555);
    check("rd9_err", {31'd0, errv}, 32'd0);

`ifdef MEM_RESPONDER_PARITY_EN
    dut.u_array.mem[9][32] = ~dut.u_array.mem[9][32];
    txn(1'b0, 1'b1, 1'b0, 32'd9, 32'd0, 1, lat, errv, ndone, bsy);
    check("parity_err", {31'd0, errv}, 32'd1);
    check("parity_rdata", rdata_1, 32'h55555555);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: DEPTH, 512, number of 32-bit words in the array; power of two, 16..4096.
REQ-002 Parameter: WAIT_STATES, 1, extra cycles inserted before array access; range 0..15.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: reset_n  input  1  reset; asynchronous, active-low.
REQ-005 Port: read  input  1  read strobe from control unit.
REQ-006 Port: write  input  1  write strobe from control unit.
REQ-007 Port: addr  input  32  word address (MAR contents).
REQ-008 Port: wdata  input  32  write data (MDR contents).
REQ-009 Port: rdata  output  32  read data to MDR; holds until next completed read.
REQ-010 Port: done  output  1  one-cycle pulse at end of any accepted transaction.
REQ-011 Port: busy  output  1  high from capture edge until the cycle done is asserted.
REQ-012 Port: err  output  1  one-cycle pulse with done when the transaction was rejected.
REQ-013 Port: overrun  output  1  sticky flag: request edge arrived while not IDLE.

Function
REQ-014 The block SHALL register read and write each cycle; a request is a rising edge of (read|write) versus the previous cycle.
REQ-015 FSM states SHALL be IDLE, WAIT, ACCESS, DONE.
REQ-016 IDLE: on a request edge, the block SHALL latch addr, wdata and op; busy goes high; next state is WAIT if WAIT_STATES>0, else ACCESS.
REQ-017 WAIT: a 4-bit counter loaded with WAIT_STATES SHALL decrement each cycle; the FSM goes to ACCESS when the counter reaches 1.
REQ-018 ACCESS: a write SHALL commit wdata to the array at the exit edge; a read SHALL load rdata at the exit edge; next state is DONE.
REQ-019 DONE: done=1 for exactly one cycle, busy=0; next state is IDLE.
REQ-020 Latency from capture edge to done high SHALL be WAIT_STATES+2 cycles.
REQ-021 read and write both rising in the same cycle SHALL be rejected: no array access, rdata unchanged, err and done pulse WAIT_STATES+2 cycles later.
REQ-022 addr >= DEPTH SHALL be rejected: a write is dropped; a read leaves rdata unchanged; err pulses with done.
REQ-023 A request edge in WAIT, ACCESS or DONE SHALL be ignored and SHALL set overrun.
REQ-024 A strobe held high across multiple cycles SHALL produce exactly one transaction.
REQ-025 Back-to-back transactions: a new edge is accepted in IDLE, one cycle after done, at the earliest.

Reset
REQ-026 On reset assertion: FSM=IDLE, rdata=0, done=0, busy=0, err=0, overrun=0, strobe history=0, counter=0.
REQ-027 Array contents SHALL NOT be reset.
REQ-028 Reset mid-transaction SHALL abort it; a write not yet past its ACCESS exit edge SHALL NOT commit.

Configuration
REQ-029 With MEM_RESPONDER_PARITY_EN defined: each word stores an even-parity bit computed on write; a read with parity mismatch loads rdata normally and pulses err with done.
REQ-030 Without MEM_RESPONDER_PARITY_EN: no parity storage, and err is driven only by REQ-021/REQ-022.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, the 32-bit word width constant, and the parity function.
REQ-032 The array SHALL be a sub-module, mem_array (single-port synchronous, 1 write/read per cycle, no reset); FSM and checks stay in mem_responder.

Verification
REQ-033 WAIT_STATES=1: write 0xDEADBEEF to addr 5, then read addr 5 -> done pulses 3 cycles after each capture; rdata=0xDEADBEEF; err=0.
REQ-034 WAIT_STATES=0: read high for 4 consecutive cycles at addr 7 -> exactly one done pulse, 2 cycles after capture; overrun=0.
REQ-035 read and write rise together at addr 3 holding 0x11111111 -> err=1 with done; a later read of addr 3 returns its prior value.
REQ-036 write to addr 512 (DEPTH=512) -> err=1; read of addr 0 unchanged.
REQ-037 Second read edge one cycle after capture -> overrun=1 until reset; only one done pulse.
REQ-038 reset_n low in ACCESS of a write of 0x12345678 to addr 9 -> all outputs 0, no done pulse, addr 9 unchanged; with MEM_RESPONDER_PARITY_EN, a forced parity-bit flip on addr 9 -> read gives err=1.
